// File: rtl/multiplier_lut.sv
// multiplier_lut: unsigned WIDTH x WIDTH multiplier built from a constant
// product table indexed by {a, b}. It also provides a one-cycle registered copy
// of the product with a valid flag.
//   clk       - rising-edge clock (registered path only)
//   rst_n     - async active-low reset; clears z_q and out_valid only
//   a, b      - unsigned operands, WIDTH bits each
//   in_valid  - captures the current product into z_q on the next edge
//   z         - combinational product, 2*WIDTH bits
//   z_q       - registered product, 2*WIDTH bits
//   out_valid - z_q was captured on the previous edge
module multiplier_lut #(
  parameter int unsigned WIDTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               in_valid,
  output logic [2*WIDTH-1:0] z,
  output logic [2*WIDTH-1:0] z_q,
  output logic               out_valid
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned NE = 1 << PW;

  // Table entry for index {i, j}: i*j evaluated by shift-and-add at elaboration.
  function automatic logic [PW-1:0] prod_f(input int unsigned idx);
    int unsigned i;
    int unsigned j;
    int unsigned acc;
    i   = idx >> WIDTH;
    j   = idx & ((32'd1 << WIDTH) - 32'd1);
    acc = 32'd0;
    for (int k = 0; k < int'(WIDTH); k++) begin
      if (j[k]) acc = acc + (i << k);
    end
    return PW'(acc);
  endfunction

  logic [PW-1:0] lut [NE];

  for (genvar g = 0; g < int'(NE); g++) begin : g_lut
    assign lut[g] = prod_f(g);
  end

  // Combinational product: a plain table read, independent of clk/rst_n.
  assign z = lut[{a, b}];

  logic [PW-1:0] prod_d, prod_q;
  logic          vld_d, vld_q;

  // Capture on in_valid; the product holds otherwise, valid drops.
  always_comb begin
    prod_d = prod_q;
    vld_d  = 1'b0;
    if (in_valid) begin
      prod_d = z;
      vld_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      prod_q <= prod_d;
      vld_q  <= vld_d;
    end
  end

  assign z_q       = prod_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_multiplier_lut.sv
// Bench for multiplier_lut: a reference model of the product and the
// registered path, checked every negedge, plus directed literal vectors and
// exhaustive sweeps for WIDTH = 1, 3 and 4.
module tb_multiplier_lut;

  logic       clk;
  logic       rst_n;
  logic [1:0] a, b;
  logic       in_valid;
  logic [3:0] z, z_q;
  logic       out_valid;

  logic       a1, b1;
  logic [1:0] z1, zq1;
  logic       ov1;
  logic [2:0] a3, b3;
  logic [5:0] z3, zq3;
  logic       ov3;
  logic [3:0] a4, b4;
  logic [7:0] z4, zq4;
  logic       ov4;
  logic       iv_off;

  int checks   = 0;
  int failures = 0;
  bit run_cmp  = 1'b0;

  multiplier_lut #(.WIDTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid),
    .z(z), .z_q(z_q), .out_valid(out_valid)
  );
  multiplier_lut #(.WIDTH(1)) dut_w1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(iv_off),
    .z(z1), .z_q(zq1), .out_valid(ov1)
  );
  multiplier_lut #(.WIDTH(3)) dut_w3 (
    .clk(clk), .rst_n(rst_n), .a(a3), .b(b3), .in_valid(iv_off),
    .z(z3), .z_q(zq3), .out_valid(ov3)
  );
  multiplier_lut #(.WIDTH(4)) dut_w4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .in_valid(iv_off),
    .z(z4), .z_q(zq4), .out_valid(ov4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model of the registered path: last captured product and valid.
  logic [3:0] m_zq;
  logic       m_ov;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_zq <= 4'd0;
      m_ov <= 1'b0;
    end else if (in_valid) begin
      m_zq <= 4'({2'b00, a} * {2'b00, b});
      m_ov <= 1'b1;
    end else begin
      m_ov <= 1'b0;
    end
  end

  // Per-cycle compare against the model (inputs change only at negedge+1 / posedge+1).
  always @(negedge clk) begin
    if (run_cmp) begin
      check("z_model", 32'(z), 32'({2'b00, a} * {2'b00, b}));
      check("zq_model", 32'(z_q), 32'(m_zq));
      check("ov_model", 32'(out_valid), 32'(m_ov));
    end
  end

  task automatic drive(input logic [1:0] na, input logic [1:0] nb, input logic niv);
    a = na;
    b = nb;
    in_valid = niv;
  endtask

  typedef struct {
    logic [1:0] va;
    logic [1:0] vb;
    logic [3:0] vz;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{2'd0, 2'd0, 4'd0};
    vecs[1] = '{2'd0, 2'd2, 4'd0};
    vecs[2] = '{2'd2, 2'd1, 4'd2};
    vecs[3] = '{2'd2, 2'd2, 4'd4};
    vecs[4] = '{2'd3, 2'd0, 4'd0};
    vecs[5] = '{2'd3, 2'd3, 4'b1001};

    rst_n = 1'b0;
    iv_off = 1'b0;
    a1 = 1'b0; b1 = 1'b0; a3 = 3'd0; b3 = 3'd0; a4 = 4'd0; b4 = 4'd0;
    drive(2'd3, 2'd3, 1'b1);
    #1;
    check("rst_zq", 32'(z_q), 32'd0);
    check("rst_ov", 32'(out_valid), 32'd0);
    check("rst_z_tracks", 32'(z), 32'd9);

    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    drive(2'd0, 2'd0, 1'b0);
    run_cmp = 1'b1;

    // Directed vectors: applied, checked one clock later.
    foreach (vecs[i]) begin
      drive(vecs[i].va, vecs[i].vb, 1'b0);
      @(posedge clk); #1;
      check("dir_z", 32'(z), 32'(vecs[i].vz));
    end

    // Exhaustive WIDTH=2 with capture enabled.
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        @(negedge clk); #1;
        drive(2'(i), 2'(j), 1'b1);
      end
    end

    // Registered path.
    @(negedge clk); #1;
    drive(2'd3, 2'd2, 1'b1);
    @(posedge clk); #1;
    check("reg_zq6", 32'(z_q), 32'd6);
    check("reg_ov1", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("reg_ov0", 32'(out_valid), 32'd0);
    check("reg_zq_hold", 32'(z_q), 32'd6);

    // Random operands and valid.
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk); #1;
      drive(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // Reset mid-operation, between edges.
    @(negedge clk); #1;
    drive(2'd3, 2'd3, 1'b1);
    @(posedge clk); #2;
    check("pre_rst_ov", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_zq", 32'(z_q), 32'd0);
    check("mid_rst_ov", 32'(out_valid), 32'd0);
    check("mid_rst_z", 32'(z), 32'd9);
    @(posedge clk); #1;
    check("rst_edge_ov", 32'(out_valid), 32'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_zq", 32'(z_q), 32'd9);
    check("post_rst_ov", 32'(out_valid), 32'd1);

    // Parameter sweep on the other widths (combinational product).
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        a1 = 1'(i); b1 = 1'(j); #1;
        check("w1_z", 32'(z1), 32'(i * j));
      end
    end
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        a3 = 3'(i); b3 = 3'(j); #1;
        check("w3_z", 32'(z3), 32'(i * j));
      end
    end
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        a4 = 4'(i); b4 = 4'(j); #1;
        check("w4_z", 32'(z4), 32'(i * j));
      end
    end
    a4 = 4'd15; b4 = 4'd15; #1;
    check("w4_max", 32'(z4), 32'h0000_00E1);
    check("w1_zq_idle", 32'({ov1, zq1}), 32'd0);
    check("w3_zq_idle", 32'({ov3, zq3}), 32'd0);
    check("w4_zq_idle", 32'({ov4, zq4}), 32'd0);

    @(negedge clk);
    run_cmp = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
